// File: rtl/cpu_alu_defs.sv
// Shared ALU definitions: sequencer state encodings and add/sub op codes.
// Reused by the ALU decoder as well as the multi-cycle adder/subtractor.
package cpu_alu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Counter width for n digits, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple of 1-bit full-adder cells.
// c_msb is the carry into the top bit, used by the caller for signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH bits processed DIGIT bits per cycle,
// with start/busy/done handshake and carry/overflow/zero flags.
module seq_add_sub
  import cpu_alu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic             c_top;
  logic [CW-1:0]    cnt;

  int               idx;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_msb;
  logic             last;

  always_comb begin
    idx  = int'(cnt) * DIGIT;
    last = (cnt == CW'(N - 1));
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (opa[idx +: DIGIT]),
    .b     (opb[idx +: DIGIT]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_msb)
  );

  // Subtraction is a + ~b + 1: invert b at capture and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      c_top  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{op_sub}};
            carry <= (op_sub == OP_SUB);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[idx +: DIGIT] <= d_sum;
          carry                <= d_cout;
          if (last) begin
            c_top <= d_msb;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cout  <= carry;
          ovf   <= carry ^ c_top;
          zero  <= (result == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: reference model pushes expected results,
// a monitor checks them when (and only when) done is due.
module tb_seq_add_sub;

  localparam int W  = 8;
  localparam int N1 = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, op_sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] result;

  logic         start_w = 1'b0, sub_w = 1'b0;
  logic [W-1:0] a_w = '0, b_w = '0;
  logic         busy4, done4, cout4, ovf4, zero4;
  logic         busy8, done8, cout8, ovf8, zero8;
  logic [W-1:0] result4, result8;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(W), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero));

  seq_add_sub #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .op_sub(sub_w), .a(a_w), .b(b_w),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4));

  seq_add_sub #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .op_sub(sub_w), .a(a_w), .b(b_w),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8));

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   next_ok  = 0;

  function automatic exp_t model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int due);
    exp_t e;
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r, sr;
    if (sub) begin
      r   = ux - uy;
      sr  = sx - sy;
      e.c = (ux >= uy);
    end else begin
      r   = ux + uy;
      sr  = sx + sy;
      e.c = (r > 255);
    end
    e.res = W'(r & 255);
    e.v   = (sr > 127) || (sr < -128);
    e.z   = ((r & 255) == 0);
    e.due = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Acceptance model: an op issued at edge k completes at k+N+1; next start allowed at k+N+2.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && start && cyc >= next_ok) begin
      q.push_back(model(op_sub, a, b, cyc + N1 + 1));
      next_ok = cyc + N1 + 2;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("done_pulse", 32'(done), 32'd1);
        check("result", 32'(result), 32'(q[0].res));
        check("cout", 32'(cout), 32'(q[0].c));
        check("ovf", 32'(ovf), 32'(q[0].v));
        check("zero", 32'(zero), 32'(q[0].z));
        void'(q.pop_front());
      end else begin
        check("done_spurious", 32'(done), 32'd0);
      end
    end
  end

  task automatic issue(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op_sub = sub; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got4, got8;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 8'h7F, 8'h01); drain();
    issue(1'b1, 8'h00, 8'h01); drain();
    issue(1'b1, 8'h80, 8'h01); drain();
    issue(1'b0, 8'hFF, 8'h01); drain();
    issue(1'b1, 8'h05, 8'h05); drain();

    for (int i = 0; i < 20; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      drain();
    end

    // Start held high with fresh operands every cycle: only idle-time starts count.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b1; op_sub = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during the fourth RUN cycle discards the operation.
    issue(1'b0, 8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    next_ok = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_all_zero("post_reset_idle");
    issue(1'b0, 8'hFF, 8'h01); drain();

    // Wider digits: latency N+1 with N=2 and N=1.
    @(negedge clk);
    start_w = 1'b1; sub_w = 1'b0; a_w = 8'h3C; b_w = 8'h0F;
    k = cyc + 1;
    got4 = -1; got8 = -1;
    @(negedge clk);
    start_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done4 && got4 < 0) got4 = cyc;
      if (done8 && got8 < 0) got8 = cyc;
      @(negedge clk);
    end
    check("d4_latency", 32'(got4 - k), 32'd3);
    check("d8_latency", 32'(got8 - k), 32'd2);
    check("d4_result", 32'(result4), 32'h4B);
    check("d8_result", 32'(result8), 32'h4B);
    check("d4_flags", {29'd0, cout4, ovf4, zero4}, 32'd0);
    check("d8_flags", {29'd0, cout8, ovf8, zero8}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
